sram_burst_requester: RTL and testbench
=======================================

Name: sram_burst_requester

Overview:
- Customer-side front end for one port of the dual-clock SRAM controller.
- Accepts a burst command (base address, length, direction) from a BOARD_CLK-domain module.
- Drives the port's QueueReadReq/QueueWriteReq/AddressToSRAM/DataToSRAM, tracks DataReady, and returns read data over a valid/ready stream.
- One instance per controller port, used by sprite, frame-buffer and CPU-side clients.

Parameters:
- MAX_LEN, 256, maximum burst length in words; cmd_len width is $clog2(MAX_LEN+1).
- TIMEOUT_CYCLES, 64, BOARD_CLK cycles allowed between read issue and DataReady return. Used only with SRAM_REQ_TIMEOUT_EN.

Ports:
- BOARD_CLK  in  1  50 MHz fabric clock; sole clock.
- Reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  burst command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  20  base word address.
- cmd_len  in  $clog2(MAX_LEN+1)  word count. 0 is illegal and completes immediately with done.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write word accepted this cycle.
- wr_data  in  16  write word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts read word.
- rd_data  out  16  read word.
- rd_last  out  1  final word of burst, qualified by rd_valid.
- done  out  1  one-cycle pulse at burst end.
- error  out  1  sticky timeout flag; always 0 without SRAM_REQ_TIMEOUT_EN.
- QueueReadReq  out  1  to controller port.
- QueueWriteReq  out  1  to controller port.
- AddressToSRAM  out  20  to controller port.
- DataToSRAM  out  16  to controller port.
- DataReady  in  1  from controller port.
- DataFromSRAM  in  16  from controller port.

Behaviour:
- Clocking: SRAM_CLK is exactly 2x BOARD_CLK from the same PLL. DataReady and DataFromSRAM are sampled directly on BOARD_CLK, with no synchronizer.
- Reset values: cmd_ready=1; all other outputs 0, including QueueReadReq, QueueWriteReq, AddressToSRAM, DataToSRAM, rd_valid, done and error. State is IDLE.
- Reset mid-burst: the burst is abandoned. Entries already queued in the controller FIFO are not recalled, and their DataReady returns are ignored after reset.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT_LOW, RD_WAIT_HIGH, RD_HOLD, DONE.
- IDLE: on cmd_valid, latch addr and remaining = cmd_len. Go to WR_ISSUE or RD_ISSUE; go straight to DONE if cmd_len==0.
- WR_ISSUE:
  - wr_ready = 1.
  - On wr_valid, register QueueWriteReq=1 for exactly one cycle, with AddressToSRAM=addr and DataToSRAM=wr_data. Then addr+1 and remaining-1.
  - Back-to-back writes run at one per cycle, with no stalls required, because the controller drains at 2x rate.
  - When remaining reaches 0, go to DONE.
- RD_ISSUE: register QueueReadReq=1 for exactly one cycle with AddressToSRAM=addr, then go to RD_WAIT_LOW.
- RD_WAIT_LOW: wait for DataReady==0, which is guaranteed within 2 cycles. Then go to RD_WAIT_HIGH.
- RD_WAIT_HIGH: on DataReady==1, capture DataFromSRAM into rd_data and set rd_valid=1. rd_last = (remaining==1). Go to RD_HOLD.
- RD_HOLD:
  - rd_data is held stable while rd_valid && !rd_ready.
  - On handshake: addr+1 and remaining-1, then go to RD_ISSUE, or to DONE if remaining becomes 0.
  - Only one read is outstanding at any time.
- DONE: done=1 for one cycle, then IDLE. cmd_ready is low here.
- Address arithmetic: 20-bit, wraps 0xFFFFF -> 0x00000 silently.
- Outputs are all registered, with no combinational path from DataReady to QueueReadReq.

Optional Feature:
- SRAM_REQ_TIMEOUT_EN defined:
  - A counter runs in RD_WAIT_LOW and RD_WAIT_HIGH and clears on entry to RD_ISSUE.
  - At TIMEOUT_CYCLES, set error=1 (sticky until Reset), drop the rest of the burst, and go to DONE. No rd_valid is produced for the timed-out word.
- Undefined: no counter is built, error is tied to 0, and the wait states block indefinitely.

Decomposition:
- Package sram_pkg holds:
  - SRAM_ADDR_W=20 and SRAM_DATA_W=16.
  - The typedefs sram_addr_t and sram_data_t.
  - The state enum req_state_e.
  - Shared by the controller and all requesters.
- One sub-module, sram_req_timer: timeout counter with clear/enable/expired, instantiated only under SRAM_REQ_TIMEOUT_EN.
- The FSM and datapath stay in the top module.

Test Plan:
- Write burst: cmd_write=1, addr=0x00010, len=4, wr_data 0xA000..0xA003 with wr_valid held -> four consecutive QueueWriteReq pulses at addresses 0x10..0x13 with matching data; done 1 cycle after the last pulse.
- Read burst: controller model returns DataFromSRAM=addr^0x5555, len=3, base 0x00100, rd_ready=1 -> rd_data 0x5455, 0x5454, 0x5457; rd_last only on the third word; exactly one QueueReadReq per word.
- Backpressure: same read burst with rd_ready low for 5 cycles on word 2 -> rd_data stable, no new QueueReadReq until the handshake.
- Wrap: read len=2 at 0xFFFFF -> AddressToSRAM 0xFFFFF, then 0x00000.
- Reset mid-burst: assert Reset in RD_WAIT_HIGH of a len=8 read -> all outputs are at reset values the same cycle; a late DataReady produces no rd_valid; a new len=1 command completes normally.
- Timeout (SRAM_REQ_TIMEOUT_EN): model never raises DataReady -> error=1 and done pulse after TIMEOUT_CYCLES=64; no rd_valid; error stays 1 across the next command.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types for the dual-clock SRAM controller and its per-port requesters.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_W-1:0] sram_data_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT_LOW,
    RD_WAIT_HIGH,
    RD_HOLD,
    DONE
  } req_state_e;

  // Word addresses wrap silently at the top of the 20-bit space.
  function automatic sram_addr_t next_addr(input sram_addr_t a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/sram_burst_requester_if.sv
// Client stream and controller-port bundle for one sram_burst_requester.
// master = requester side, slave = client plus controller port.
interface sram_burst_requester_if
  import sram_pkg::*;
#(
  parameter int LEN_W = 9
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  sram_addr_t       cmd_addr;
  logic [LEN_W-1:0] cmd_len;

  logic             wr_valid;
  logic             wr_ready;
  sram_data_t       wr_data;

  logic             rd_valid;
  logic             rd_ready;
  sram_data_t       rd_data;
  logic             rd_last;

  logic             done;
  logic             error;

  logic             QueueReadReq;
  logic             QueueWriteReq;
  sram_addr_t       AddressToSRAM;
  sram_data_t       DataToSRAM;
  logic             DataReady;
  sram_data_t       DataFromSRAM;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output done, error,
    output QueueReadReq, QueueWriteReq, AddressToSRAM, DataToSRAM,
    input  DataReady, DataFromSRAM
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  done, error,
    input  QueueReadReq, QueueWriteReq, AddressToSRAM, DataToSRAM,
    output DataReady, DataFromSRAM
  );

endinterface

// File: rtl/sram_req_timer.sv
// Read-return watchdog: counts cycles while enabled, flags the LIMIT-th cycle.
module sram_req_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = en && (count_q == LAST);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state updates use <= so all flops see pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sram_burst_requester.sv
// Burst front end for one SRAM controller port: one write per cycle, one read outstanding.
// Optional read-return timeout with sticky error is built when SRAM_REQ_TIMEOUT_EN is defined.
module sram_burst_requester
  import sram_pkg::*;
#(
  parameter int MAX_LEN        = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                   BOARD_CLK,
  input logic                   Reset,
  sram_burst_requester_if.master bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  typedef logic [LEN_W-1:0] len_t;

  if (MAX_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("sram_burst_requester: MAX_LEN must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  req_state_e state_q, state_d;
  sram_addr_t addr_q, addr_d;
  len_t       remaining_q, remaining_d;

  logic       cmd_ready_q, cmd_ready_d;
  logic       wr_ready_q, wr_ready_d;
  logic       queue_read_req_q, queue_read_req_d;
  logic       queue_write_req_q, queue_write_req_d;
  sram_addr_t address_to_sram_q, address_to_sram_d;
  sram_data_t data_to_sram_q, data_to_sram_d;
  logic       rd_valid_q, rd_valid_d;
  sram_data_t rd_data_q, rd_data_d;
  logic       rd_last_q, rd_last_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic       timer_expired;

`ifdef SRAM_REQ_TIMEOUT_EN
  logic timer_en;
  logic timer_clr;

  assign timer_en  = (state_q == RD_WAIT_LOW) || (state_q == RD_WAIT_HIGH);
  assign timer_clr = (state_q == RD_ISSUE);

  sram_req_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (BOARD_CLK),
    .rst     (Reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    remaining_d       = remaining_q;
    queue_read_req_d  = 1'b0;
    queue_write_req_d = 1'b0;
    address_to_sram_d = address_to_sram_q;
    data_to_sram_d    = data_to_sram_q;
    rd_valid_d        = rd_valid_q;
    rd_data_d         = rd_data_q;
    rd_last_d         = rd_last_q;
    done_d            = 1'b0;
    error_d           = error_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d      = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            state_d = DONE;
          end else if (bus.cmd_write) begin
            state_d = WR_ISSUE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end

      WR_ISSUE: begin
        if (bus.wr_valid) begin
          queue_write_req_d = 1'b1;
          address_to_sram_d = addr_q;
          data_to_sram_d    = bus.wr_data;
          addr_d            = next_addr(addr_q);
          remaining_d       = remaining_q - 1'b1;
          if (remaining_q == len_t'(1)) begin
            state_d = DONE;
          end
        end
      end

      RD_ISSUE: begin
        queue_read_req_d  = 1'b1;
        address_to_sram_d = addr_q;
        state_d           = RD_WAIT_LOW;
      end

      // DataReady may still be high from the previous word until the controller dequeues.
      RD_WAIT_LOW: begin
        if (timer_expired) begin
          error_d = 1'b1;
          state_d = DONE;
        end else if (!bus.DataReady) begin
          state_d = RD_WAIT_HIGH;
        end
      end

      RD_WAIT_HIGH: begin
        if (bus.DataReady) begin
          rd_valid_d = 1'b1;
          rd_data_d  = bus.DataFromSRAM;
          rd_last_d  = (remaining_q == len_t'(1));
          state_d    = RD_HOLD;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end

      RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_valid_d  = 1'b0;
          rd_last_d   = 1'b0;
          addr_d      = next_addr(addr_q);
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q == len_t'(1)) ? DONE : RD_ISSUE;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Handshake readies are registered copies of the next state.
    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WR_ISSUE);
  end

  always_ff @(posedge BOARD_CLK or posedge Reset) begin
    if (Reset) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      remaining_q       <= '0;
      cmd_ready_q       <= 1'b1;
      wr_ready_q        <= 1'b0;
      queue_read_req_q  <= 1'b0;
      queue_write_req_q <= 1'b0;
      address_to_sram_q <= '0;
      data_to_sram_q    <= '0;
      rd_valid_q        <= 1'b0;
      rd_data_q         <= '0;
      rd_last_q         <= 1'b0;
      done_q            <= 1'b0;
      error_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      remaining_q       <= remaining_d;
      cmd_ready_q       <= cmd_ready_d;
      wr_ready_q        <= wr_ready_d;
      queue_read_req_q  <= queue_read_req_d;
      queue_write_req_q <= queue_write_req_d;
      address_to_sram_q <= address_to_sram_d;
      data_to_sram_q    <= data_to_sram_d;
      rd_valid_q        <= rd_valid_d;
      rd_data_q         <= rd_data_d;
      rd_last_q         <= rd_last_d;
      done_q            <= done_d;
      error_q           <= error_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.wr_ready      = wr_ready_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_last       = rd_last_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.QueueReadReq  = queue_read_req_q;
  assign bus.QueueWriteReq = queue_write_req_q;
  assign bus.AddressToSRAM = address_to_sram_q;
  assign bus.DataToSRAM    = data_to_sram_q;

endmodule

// File: tb/tb_sram_burst_requester.sv
// Directed bench for sram_burst_requester with a behavioural controller-port model.
module tb_sram_burst_requester;

  localparam int MAX_LEN = 256;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sram_burst_requester_if #(.LEN_W(LEN_W)) bus ();

  sram_burst_requester #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .BOARD_CLK (clk),
    .Reset     (rst),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit ctl_mute = 1'b0;

  logic [19:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int          wr_cyc_log[$];
  logic [19:0] req_log[$];
  int          req_cyc_log[$];
  logic [15:0] rd_word_log[$];
  logic        rd_last_log[$];
  int          done_cyc_log[$];
  int          rd_valid_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.QueueWriteReq) begin
      wr_addr_log.push_back(bus.AddressToSRAM);
      wr_data_log.push_back(bus.DataToSRAM);
      wr_cyc_log.push_back(cyc);
    end
    if (bus.QueueReadReq) begin
      req_log.push_back(bus.AddressToSRAM);
      req_cyc_log.push_back(cyc);
    end
    if (bus.rd_valid) rd_valid_seen++;
    if (bus.rd_valid && bus.rd_ready) begin
      rd_word_log.push_back(bus.rd_data);
      rd_last_log.push_back(bus.rd_last);
    end
    if (bus.done) done_cyc_log.push_back(cyc);
  end

  // Controller port: drops DataReady on each request, returns addr^0x5555 three cycles later.
  initial begin
    logic [19:0] pend_addr;
    int          pend_cnt;
    pend_addr        = '0;
    pend_cnt         = 0;
    bus.DataReady    = 1'b0;
    bus.DataFromSRAM = '0;
    forever begin
      @(negedge clk);
      if (bus.QueueReadReq) begin
        pend_addr     = bus.AddressToSRAM;
        pend_cnt      = 3;
        bus.DataReady = 1'b0;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0 && !ctl_mute) begin
          bus.DataReady    = 1'b1;
          bus.DataFromSRAM = pend_addr[15:0] ^ 16'h5555;
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_cyc_log.delete();
    req_log.delete();
    req_cyc_log.delete();
    rd_word_log.delete();
    rd_last_log.delete();
    done_cyc_log.delete();
    rd_valid_seen = 0;
  endtask

  task automatic issue_cmd(input logic w, input logic [19:0] a, input int len);
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      step();
      k++;
    end
    check("cmd_ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = LEN_W'(len);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int k;
    start = done_cyc_log.size();
    k = 0;
    while (done_cyc_log.size() == start && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, done_cyc_log.size() - start, 1);
  endtask

  task automatic write_burst(input logic [19:0] a, input int len, input logic [15:0] d0);
    int taken;
    int k;
    bit take;
    taken = 0;
    k = 0;
    issue_cmd(1'b1, a, len);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d0;
    while (taken < len && k < 4 * len + 10) begin
      take = bus.wr_ready && bus.wr_valid;
      step();
      k++;
      if (take) begin
        taken++;
        bus.wr_data = d0 + 16'(taken);
      end
    end
    bus.wr_valid = 1'b0;
  endtask

  // Waits for a read word, holds it `hold` cycles checking stability, then accepts it.
  task automatic read_word(input string tag, input int idx, input int hold, input logic [15:0] exp);
    int k;
    k = 0;
    while (!bus.rd_valid && k < 50) begin
      step();
      k++;
    end
    check({tag, "_valid"}, bus.rd_valid, 1);
    check({tag, "_data"}, bus.rd_data, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_data"}, bus.rd_data, exp);
      check({tag, "_hold_noreq"}, req_log.size(), idx + 1);
    end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_qwr", bus.QueueWriteReq, 0);
    check("rst_qrd", bus.QueueReadReq, 0);
    rst = 1'b0;
    step();
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_wr_ready", bus.wr_ready, 0);
    check("idle_rd_valid", bus.rd_valid, 0);
    check("idle_done", bus.done, 0);
    check("idle_error", bus.error, 0);
    check("idle_addr", bus.AddressToSRAM, 20'h0);
    check("idle_wdata", bus.DataToSRAM, 16'h0);

    // Write burst: four back-to-back pulses, done one cycle after the last
    clear_logs();
    write_burst(20'h00010, 4, 16'hA000);
    wait_done("wr", 20);
    check("wr_pulses", wr_addr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      check($sformatf("wr_addr%0d", i), wr_addr_log[i], 20'h00010 + 20'(i));
      check($sformatf("wr_data%0d", i), wr_data_log[i], 16'hA000 + 16'(i));
      check($sformatf("wr_cyc%0d", i), wr_cyc_log[i] - wr_cyc_log[0], i);
    end
    if (wr_cyc_log.size() == 4 && done_cyc_log.size() == 1)
      check("wr_done_lag", done_cyc_log[0] - wr_cyc_log[3], 1);
    check("wr_no_reads", req_log.size(), 0);
    step();

    // Read burst with the consumer always ready
    clear_logs();
    bus.rd_ready = 1'b1;
    issue_cmd(1'b0, 20'h00100, 3);
    wait_done("rd", 200);
    bus.rd_ready = 1'b0;
    check("rd_words", rd_word_log.size(), 3);
    check("rd_reqs", req_log.size(), 3);
    for (int i = 0; i < 3 && i < rd_word_log.size() && i < req_log.size(); i++) begin
      check($sformatf("rd_req_addr%0d", i), req_log[i], 20'h00100 + 20'(i));
      check($sformatf("rd_last%0d", i), rd_last_log[i], (i == 2) ? 1 : 0);
    end
    if (rd_word_log.size() == 3) begin
      check("rd_word0", rd_word_log[0], 16'h5455);
      check("rd_word1", rd_word_log[1], 16'h5454);
      check("rd_word2", rd_word_log[2], 16'h5457);
    end
    step();

    // Backpressure: word 2 held for five cycles
    clear_logs();
    issue_cmd(1'b0, 20'h00100, 3);
    read_word("bp0", 0, 0, 16'h5455);
    read_word("bp1", 1, 5, 16'h5454);
    read_word("bp2", 2, 0, 16'h5457);
    wait_done("bp", 20);
    check("bp_reqs", req_log.size(), 3);
    check("bp_words", rd_word_log.size(), 3);
    step();

    // Address wrap
    clear_logs();
    bus.rd_ready = 1'b1;
    issue_cmd(1'b0, 20'hFFFFF, 2);
    wait_done("wrap", 200);
    bus.rd_ready = 1'b0;
    check("wrap_reqs", req_log.size(), 2);
    if (req_log.size() == 2 && rd_word_log.size() == 2) begin
      check("wrap_addr0", req_log[0], 20'hFFFFF);
      check("wrap_addr1", req_log[1], 20'h00000);
      check("wrap_word0", rd_word_log[0], 16'hAAAA);
      check("wrap_word1", rd_word_log[1], 16'h5555);
    end
    step();

    // Reset while waiting for DataReady on the first word of a len=8 read
    clear_logs();
    bus.rd_ready = 1'b1;
    issue_cmd(1'b0, 20'h00200, 8);
    begin
      int k;
      k = 0;
      while (req_log.size() == 0 && k < 20) begin
        step();
        k++;
      end
    end
    check("mid_req_seen", req_log.size(), 1);
    check("mid_no_valid", bus.rd_valid, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_qrd", bus.QueueReadReq, 0);
    check("mid_rst_qwr", bus.QueueWriteReq, 0);
    check("mid_rst_addr", bus.AddressToSRAM, 20'h0);
    check("mid_rst_rd_valid", bus.rd_valid, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_error", bus.error, 0);
    check("mid_rst_wr_ready", bus.wr_ready, 0);
    step();
    step();
    rst = 1'b0;
    rd_valid_seen = 0;
    repeat (6) step();
    check("late_dr_no_valid", rd_valid_seen, 0);
    check("late_dr_no_req", req_log.size(), 1);
    check("late_dr_no_done", done_cyc_log.size(), 0);
    clear_logs();
    issue_cmd(1'b0, 20'h00300, 1);
    wait_done("post_rst", 200);
    bus.rd_ready = 1'b0;
    check("post_rst_words", rd_word_log.size(), 1);
    if (rd_word_log.size() == 1) begin
      check("post_rst_word", rd_word_log[0], 16'h5655);
      check("post_rst_last", rd_last_log[0], 1);
    end
    step();

    // Zero-length command completes with done and no port traffic
    clear_logs();
    issue_cmd(1'b0, 20'h00400, 0);
    wait_done("len0", 10);
    check("len0_reqs", req_log.size() + wr_addr_log.size(), 0);
    step();

`ifdef SRAM_REQ_TIMEOUT_EN
    // Timeout: controller never returns data
    clear_logs();
    ctl_mute     = 1'b1;
    bus.rd_ready = 1'b1;
    issue_cmd(1'b0, 20'h00400, 2);
    wait_done("to", 300);
    bus.rd_ready = 1'b0;
    check("to_error", bus.error, 1);
    check("to_no_valid", rd_valid_seen, 0);
    check("to_reqs", req_log.size(), 1);
    if (req_cyc_log.size() == 1 && done_cyc_log.size() == 1)
      check("to_latency", done_cyc_log[0] - req_cyc_log[0], TIMEOUT + 1);
    ctl_mute = 1'b0;
    step();
    clear_logs();
    write_burst(20'h00500, 1, 16'hBEEF);
    wait_done("to_next", 20);
    check("to_sticky", bus.error, 1);
`else
    check("no_timeout_error", bus.error, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
